// File: rtl/uart_alu_sequencer.sv
// Command sequencer between UART RX/TX and a combinational ALU: buffers RX words,
// frames them as A, B, OP, waits out the ALU latency and hands the result to TX.
module uart_alu_sequencer #(
  parameter int N_DATA         = 8,
  parameter int NB_OPERATION   = 6,
  parameter int PARITY_CHECK   = 1,
  parameter int N_WORD_BUFFER  = 4,
  parameter int ALU_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [N_DATA+PARITY_CHECK-1:0] i_rx_data,
  input  logic                           i_rx_done,
  output logic [N_DATA-1:0]              o_alu_data_a,
  output logic [N_DATA-1:0]              o_alu_data_b,
  output logic [NB_OPERATION-1:0]        o_alu_data_op,
  input  logic [N_DATA-1:0]              i_alu_data,
  output logic [N_DATA-1:0]              o_tx_data,
  output logic                           o_tx_start,
  input  logic                           i_tx_done,
  output logic                           o_rx_overflow,
  output logic                           o_parity_err,
  output logic                           o_timeout,
  output logic                           o_busy
);

  localparam int W  = N_DATA + PARITY_CHECK;
  localparam int AW = $clog2(N_WORD_BUFFER);
  localparam int LW = $clog2(ALU_LATENCY + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, SEND_WAIT
  } state_e;

  state_e                  state_q;
  logic [W-1:0]            mem_q [N_WORD_BUFFER];
  logic [AW:0]             wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LW-1:0]           latCnt_q;
  logic [TW-1:0]           idleCnt_q;
  logic [N_DATA-1:0]       aluA_q, aluB_q, txData_q;
  logic [NB_OPERATION-1:0] aluOp_q;
  logic                    overflow_q, parityErr_q, timeout_q;

  logic                    empty, full, pop, push, parityOk;
  logic [W-1:0]            head;
  logic [N_DATA-1:0]       payload;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty    = (wrPtr_q == rdPtr_q);
  assign full     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign pop      = !empty && (state_q inside {WAIT_A, WAIT_B, WAIT_OP});
  assign push     = i_rx_done && (!full || pop);
  assign head     = mem_q[rdPtr_q[AW-1:0]];
  assign payload  = head[N_DATA-1:0];
  assign parityOk = (PARITY_CHECK == 0) || !(^head);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (push) wrPtr_d = wrPtr_q + (AW+1)'(1);
    if (pop)  rdPtr_d = rdPtr_q + (AW+1)'(1);
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wrPtr_q[AW-1:0]] <= i_rx_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      overflow_q <= i_rx_done && full && !pop;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= WAIT_A;
      latCnt_q    <= '0;
      idleCnt_q   <= '0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluOp_q     <= '0;
      txData_q    <= '0;
      parityErr_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      parityErr_q <= 1'b0;
      timeout_q   <= 1'b0;
      case (state_q)
        WAIT_A: begin
          if (pop) begin
            if (!parityOk) begin
              parityErr_q <= 1'b1;
            end else begin
              aluA_q    <= payload;
              idleCnt_q <= '0;
              state_q   <= WAIT_B;
            end
          end
        end
        WAIT_B, WAIT_OP: begin
          // A pop always beats the idle limit, so parity errors win over timeouts.
          if (pop) begin
            idleCnt_q <= '0;
            if (!parityOk) begin
              parityErr_q <= 1'b1;
              state_q     <= WAIT_A;
            end else if (state_q == WAIT_B) begin
              aluB_q  <= payload;
              state_q <= WAIT_OP;
            end else begin
              aluOp_q  <= payload[NB_OPERATION-1:0];
              latCnt_q <= '0;
              state_q  <= EXEC;
            end
          end else if (idleCnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            idleCnt_q <= '0;
            timeout_q <= 1'b1;
            state_q   <= WAIT_A;
          end else begin
            idleCnt_q <= idleCnt_q + TW'(1);
          end
        end
        EXEC: begin
          if (latCnt_q == LW'(ALU_LATENCY - 1)) begin
            txData_q <= i_alu_data;
            state_q  <= SEND;
          end else begin
            latCnt_q <= latCnt_q + LW'(1);
          end
        end
        SEND:      state_q <= SEND_WAIT;
        SEND_WAIT: if (i_tx_done) state_q <= WAIT_A;
        default:   state_q <= WAIT_A;
      endcase
    end
  end

  assign o_alu_data_a  = aluA_q;
  assign o_alu_data_b  = aluB_q;
  assign o_alu_data_op = aluOp_q;
  assign o_tx_data     = txData_q;
  assign o_tx_start    = (state_q == SEND);
  assign o_busy        = (state_q inside {EXEC, SEND, SEND_WAIT});
  assign o_rx_overflow = overflow_q;
  assign o_parity_err  = (PARITY_CHECK != 0) && parityErr_q;
  assign o_timeout     = timeout_q;

endmodule
